// File: rtl/prj_processor_prog_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words, writes them to program
// memory over Avalon-MM, optionally read-back verifies them, and holds the CPU in reset meanwhile.
module prj_processor_prog_loader #(
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 20000,
    parameter int VERIFY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_last_i,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_chipselect_o,
    output logic              mem_write_o,
    output logic [3:0]        mem_byteenable_o,
    output logic [31:0]       mem_writedata_o,
    input  logic [31:0]       mem_readdata_i,
    output logic              mem_clken_o,
    output logic              cpu_reset_req_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic [31:0]       checksum_o
);
    typedef enum logic [2:0] {
        StIdle, StLoad, StWrite, StVerify, StDone, StError
    } state_e;

    localparam logic [ADDR_W:0] DepthW = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] OneW   = (ADDR_W+1)'(1);

    state_e          state_q, state_d;
    logic [1:0]      lane_q, lane_d;
    logic [31:0]     wordBuf_q, wordBuf_d;
    logic [3:0]      beBuf_q, beBuf_d;
    logic            lastSeen_q, lastSeen_d;
    logic [ADDR_W:0] wordCount_q, wordCount_d;
    logic [31:0]     checksum_q, checksum_d;
    logic [3:0]      lastBe_q, lastBe_d;
    logic [ADDR_W:0] rdIdx_q, rdIdx_d;
    logic            capValid_q, capValid_d;
    logic            capLast_q, capLast_d;
    logic [31:0]     vsum_q, vsum_d;
    logic            busy_q, busy_d;
    logic            cpuReset_q, cpuReset_d;
    logic            error_q, error_d;
    logic [31:0]     readMasked;
    logic [31:0]     verifySum;
    logic            issuing;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            wordBuf_q   <= '0;
            beBuf_q     <= '0;
            lastSeen_q  <= 1'b0;
            wordCount_q <= '0;
            checksum_q  <= '0;
            lastBe_q    <= '0;
            rdIdx_q     <= '0;
            capValid_q  <= 1'b0;
            capLast_q   <= 1'b0;
            vsum_q      <= '0;
            busy_q      <= 1'b0;
            cpuReset_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            wordBuf_q   <= wordBuf_d;
            beBuf_q     <= beBuf_d;
            lastSeen_q  <= lastSeen_d;
            wordCount_q <= wordCount_d;
            checksum_q  <= checksum_d;
            lastBe_q    <= lastBe_d;
            rdIdx_q     <= rdIdx_d;
            capValid_q  <= capValid_d;
            capLast_q   <= capLast_d;
            vsum_q      <= vsum_d;
            busy_q      <= busy_d;
            cpuReset_q  <= cpuReset_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        wordBuf_d   = wordBuf_q;
        beBuf_d     = beBuf_q;
        lastSeen_d  = lastSeen_q;
        wordCount_d = wordCount_q;
        checksum_d  = checksum_q;
        lastBe_d    = lastBe_q;
        rdIdx_d     = rdIdx_q;
        capValid_d  = 1'b0;
        capLast_d   = 1'b0;
        vsum_d      = vsum_q;
        busy_d      = busy_q;
        cpuReset_d  = cpuReset_q;
        error_d     = error_q;

        in_ready_o       = 1'b0;
        mem_address_o    = '0;
        mem_chipselect_o = 1'b0;
        mem_write_o      = 1'b0;
        mem_byteenable_o = '0;
        mem_writedata_o  = '0;
        done_o           = 1'b0;

        // Only the final word may be partial; unwritten lanes hold stale memory contents.
        readMasked = mem_readdata_i;
        if (capLast_q) begin
            for (int n = 0; n < 4; n++) begin
                if (!lastBe_q[n]) readMasked[8*n +: 8] = 8'h00;
            end
        end
        verifySum = vsum_q + readMasked;
        issuing   = (rdIdx_q < wordCount_q);

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    wordCount_d = '0;
                    checksum_d  = '0;
                    lane_d      = '0;
                    wordBuf_d   = '0;
                    beBuf_d     = '0;
                    lastSeen_d  = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    cpuReset_d  = 1'b1;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    if (wordCount_q == DepthW) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StError;
                    end else begin
                        wordBuf_d[{lane_q, 3'b000} +: 8] = in_data_i;
                        beBuf_d[lane_q] = 1'b1;
                        if (lane_q == 2'd3 || in_last_i) begin
                            lastSeen_d = in_last_i;
                            state_d    = StWrite;
                        end else begin
                            lane_d = lane_q + 2'd1;
                        end
                    end
                end
            end
            StWrite: begin
                mem_chipselect_o = 1'b1;
                mem_write_o      = 1'b1;
                mem_address_o    = wordCount_q[ADDR_W-1:0];
                mem_byteenable_o = beBuf_q;
                mem_writedata_o  = wordBuf_q;
                wordCount_d      = wordCount_q + OneW;
                checksum_d       = checksum_q + wordBuf_q;
                lastBe_d         = beBuf_q;
                lane_d           = '0;
                wordBuf_d        = '0;
                beBuf_d          = '0;
                rdIdx_d          = '0;
                vsum_d           = '0;
                if (!lastSeen_q)      state_d = StLoad;
                else if (VERIFY != 0) state_d = StVerify;
                else                  state_d = StDone;
            end
            StVerify: begin
                if (issuing) begin
                    mem_chipselect_o = 1'b1;
                    mem_address_o    = rdIdx_q[ADDR_W-1:0];
                    rdIdx_d          = rdIdx_q + OneW;
                end
                capValid_d = issuing;
                capLast_d  = issuing && (rdIdx_q == wordCount_q - OneW);
                if (capValid_q) begin
                    vsum_d = verifySum;
                    if (capLast_q) begin
                        if (verifySum == checksum_q) begin
                            state_d = StDone;
                        end else begin
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StError;
                        end
                    end
                end
            end
            StDone: begin
                done_o     = 1'b1;
                busy_d     = 1'b0;
                cpuReset_d = 1'b0;
                state_d    = StIdle;
            end
            StError: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_clken_o     = 1'b1;
    assign cpu_reset_req_o = cpuReset_q;
    assign busy_o          = busy_q;
    assign error_o         = error_q;
    assign word_count_o    = wordCount_q;
    assign checksum_o      = checksum_q;

endmodule

// File: tb/tb_prj_processor_prog_loader.sv
// Testbench for prj_processor_prog_loader: random byte images checked against a word-packing
// model, with a byte-enable aware memory model that can corrupt readback.
module tb_prj_processor_prog_loader;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 4;
    localparam int MEMW   = 16;

    logic              clk = 1'b0;
    logic              reset, start, in_valid, in_last;
    logic [7:0]        in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              cpu_reset_req, busy, done, error;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    always #5 clk = ~clk;

    prj_processor_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .VERIFY(1)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
        .mem_address_o(mem_address), .mem_chipselect_o(mem_chipselect), .mem_write_o(mem_write),
        .mem_byteenable_o(mem_byteenable), .mem_writedata_o(mem_writedata),
        .mem_readdata_i(mem_readdata), .mem_clken_o(mem_clken),
        .cpu_reset_req_o(cpu_reset_req), .busy_o(busy), .done_o(done), .error_o(error),
        .word_count_o(word_count), .checksum_o(checksum)
    );

    // Memory model plus bus monitors; clearLog refills memory with ones and clears the logs.
    logic [31:0] mem [MEMW];
    logic        clearLog = 1'b0;
    int          corruptAddr = -1;
    int          wrAddr[$];
    logic [31:0] wrData[$];
    logic [3:0]  wrBe[$];
    int          highAccess = 0, readyDuringWrite = 0, doneCount = 0;

    always @(posedge clk) begin
        if (clearLog) begin
            for (int i = 0; i < MEMW; i++) mem[i] <= 32'hFFFF_FFFF;
            wrAddr.delete(); wrData.delete(); wrBe.delete();
            highAccess = 0; readyDuringWrite = 0; doneCount = 0;
        end else begin
            if (done) doneCount++;
            if (mem_chipselect) begin
                if (int'(mem_address) >= DEPTH) highAccess++;
                if (mem_write) begin
                    if (in_ready) readyDuringWrite++;
                    wrAddr.push_back(int'(mem_address));
                    wrData.push_back(mem_writedata);
                    wrBe.push_back(mem_byteenable);
                    for (int j = 0; j < 4; j++)
                        if (mem_byteenable[j]) mem[int'(mem_address) % MEMW][8*j +: 8] <= mem_writedata[8*j +: 8];
                end else begin
                    mem_readdata <= mem[int'(mem_address) % MEMW] ^
                                    ((int'(mem_address) == corruptAddr) ? 32'h0000_0100 : 32'h0);
                end
            end
        end
    end

    int          tests = 0, fails = 0;
    logic [7:0]  img [32];
    logic [31:0] expData[$];
    logic [3:0]  expBe[$];
    int          expCount;
    logic [31:0] expSum;

    // Reference: little-endian packing of the image, truncated to DEPTH words on overflow.
    task automatic build_model(input int n);
        logic [31:0] d;
        logic [3:0]  b;
        int nw;
        expData.delete(); expBe.delete();
        nw = (n + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        expSum = 32'h0;
        for (int w = 0; w < nw; w++) begin
            d = 32'h0; b = 4'h0;
            for (int j = 0; j < 4; j++) begin
                if (4*w + j < n) begin
                    d = d + (32'(img[4*w + j]) << (8*j));
                    b = b | 4'(1 << j);
                end
            end
            expData.push_back(d); expBe.push_back(b);
            expSum = expSum + d;
        end
        expCount = nw;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) img[i] = 8'($urandom);
    endtask

    task automatic clear_env();
        @(negedge clk); clearLog = 1'b1;
        @(negedge clk); clearLog = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic feed(input int n, input int lastIdx, input int gapPct, input bit extraStart,
                        output bit timedOut);
        int i = 0;
        int cyc = 0;
        while (i < n && cyc < 2000) begin
            if ($urandom_range(0, 99) < gapPct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1; in_data = img[i]; in_last = (i == lastIdx);
            end
            if (extraStart) start = ($urandom_range(0, 3) == 0);
            if (in_valid && in_ready) i++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        timedOut = (i < n);
    endtask

    task automatic wait_end(output bit timedOut);
        timedOut = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (doneCount > 0 || error) begin timedOut = 1'b0; break; end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h0;
        clearLog = 1'b1;
        repeat (3) @(negedge clk);
        clearLog = 1'b0;
        tests++; if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error, mem_clken} !== 8'b0000_0001) begin
            fails++; $display("[TB] FAIL reset_ctrl got %b want 00000001", {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error, mem_clken}); end
        tests++; if (word_count !== '0 || checksum !== 32'h0) begin
            fails++; $display("[TB] FAIL reset_counts got wc=%0d sum=%h want 0/0", word_count, checksum); end
        tests++; if (mem_byteenable !== 4'h0 || mem_writedata !== 32'h0 || mem_address !== '0) begin
            fails++; $display("[TB] FAIL reset_bus got be=%b d=%h a=%0d want zeros", mem_byteenable, mem_writedata, mem_address); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL idle_hold got busy=%b rdy=%b want 0/0", busy, in_ready); end
    endtask

    task automatic test_eight_bytes();
        bit to1, to2;
        clear_env();
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        build_model(8);
        start_pulse();
        tests++; if (busy !== 1'b1 || cpu_reset_req !== 1'b1 || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL start_state got busy=%b cpurst=%b rdy=%b want 1/1/1", busy, cpu_reset_req, in_ready); end
        feed(8, 7, 0, 1'b0, to1);
        wait_end(to2);
        tests++; if (to1 || to2) begin fails++; $display("[TB] FAIL eight_timeout got %b%b want 00", to1, to2); end
        tests++; if (wrAddr.size() !== 2) begin fails++; $display("[TB] FAIL eight_nwrites got %0d want 2", wrAddr.size()); end
        for (int w = 0; w < expCount && w < wrAddr.size(); w++) begin
            tests++; if (wrAddr[w] !== w || wrData[w] !== expData[w] || wrBe[w] !== 4'b1111) begin
                fails++; $display("[TB] FAIL eight_write%0d got a=%0d d=%h be=%b want a=%0d d=%h be=1111", w, wrAddr[w], wrData[w], wrBe[w], w, expData[w]); end
        end
        tests++; if (word_count !== 16'd2 || checksum !== 32'h0C0A_0806) begin
            fails++; $display("[TB] FAIL eight_totals got wc=%0d sum=%h want 2/0c0a0806", word_count, checksum); end
        tests++; if (doneCount !== 1 || error !== 1'b0 || cpu_reset_req !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("[TB] FAIL eight_status got done=%0d err=%b cpurst=%b busy=%b want 1/0/0/0", doneCount, error, cpu_reset_req, busy); end
    endtask

    task automatic test_partial_word();
        bit to1, to2;
        clear_env();
        for (int i = 0; i < 5; i++) img[i] = 8'(i + 1);
        start_pulse();
        feed(5, 4, 0, 1'b0, to1);
        wait_end(to2);
        tests++; if (to1 || to2) begin fails++; $display("[TB] FAIL partial_timeout got %b%b want 00", to1, to2); end
        tests++; if (wrAddr.size() !== 2 || wrData[1] !== 32'h0000_0005 || wrBe[1] !== 4'b0001) begin
            fails++; $display("[TB] FAIL partial_word1 got n=%0d d=%h be=%b want 2/00000005/0001", wrAddr.size(), wrData[1], wrBe[1]); end
        tests++; if (mem[1] !== 32'hFFFF_FF05) begin
            fails++; $display("[TB] FAIL partial_mem1 got %h want ffffff05", mem[1]); end
        tests++; if (doneCount !== 1 || error !== 1'b0 || checksum !== 32'h0403_0206) begin
            fails++; $display("[TB] FAIL partial_verify got done=%0d err=%b sum=%h want 1/0/04030206", doneCount, error, checksum); end
    endtask

    task automatic test_overflow();
        bit to1, to2;
        clear_env();
        fill_random(17);
        build_model(17);
        start_pulse();
        feed(17, 16, 20, 1'b0, to1);
        wait_end(to2);
        tests++; if (to1 || to2) begin fails++; $display("[TB] FAIL ovf_timeout got %b%b want 00", to1, to2); end
        tests++; if (wrAddr.size() !== DEPTH || highAccess !== 0) begin
            fails++; $display("[TB] FAIL ovf_writes got n=%0d high=%0d want %0d/0", wrAddr.size(), highAccess, DEPTH); end
        for (int w = 0; w < expCount && w < wrAddr.size(); w++) begin
            tests++; if (wrAddr[w] !== w || wrData[w] !== expData[w] || wrBe[w] !== expBe[w]) begin
                fails++; $display("[TB] FAIL ovf_write%0d got a=%0d d=%h be=%b want a=%0d d=%h be=%b", w, wrAddr[w], wrData[w], wrBe[w], w, expData[w], expBe[w]); end
        end
        tests++; if (error !== 1'b1 || doneCount !== 0 || cpu_reset_req !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL ovf_status got err=%b done=%0d cpurst=%b busy=%b rdy=%b want 1/0/1/0/0", error, doneCount, cpu_reset_req, busy, in_ready); end
        tests++; if (word_count !== 16'(DEPTH) || checksum !== expSum) begin
            fails++; $display("[TB] FAIL ovf_totals got wc=%0d sum=%h want %0d/%h", word_count, checksum, DEPTH, expSum); end
    endtask

    task automatic test_verify_corrupt();
        bit to1, to2;
        corruptAddr = 1;
        clear_env();
        fill_random(8);
        build_model(8);
        start_pulse();
        feed(8, 7, 0, 1'b0, to1);
        wait_end(to2);
        tests++; if (to1 || to2) begin fails++; $display("[TB] FAIL corrupt_timeout got %b%b want 00", to1, to2); end
        tests++; if (error !== 1'b1 || doneCount !== 0 || cpu_reset_req !== 1'b1) begin
            fails++; $display("[TB] FAIL corrupt_status got err=%b done=%0d cpurst=%b want 1/0/1", error, doneCount, cpu_reset_req); end
        tests++; if (checksum !== expSum || wrAddr.size() !== 2) begin
            fails++; $display("[TB] FAIL corrupt_writes got sum=%h n=%0d want %h/2", checksum, wrAddr.size(), expSum); end
        corruptAddr = -1;
    endtask

    task automatic test_random_images();
        bit to1, to2;
        int n;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 1 : (it == 1) ? 16 : int'($urandom_range(2, 15));
            clear_env();
            fill_random(n);
            build_model(n);
            start_pulse();
            feed(n, n - 1, 30, 1'b0, to1);
            wait_end(to2);
            tests++; if (to1 || to2 || wrAddr.size() !== expCount) begin
                fails++; $display("[TB] FAIL rand%0d_writes got n=%0d to=%b%b want %0d/00", it, wrAddr.size(), to1, to2, expCount); end
            for (int w = 0; w < expCount && w < wrAddr.size(); w++) begin
                tests++; if (wrAddr[w] !== w || wrData[w] !== expData[w] || wrBe[w] !== expBe[w]) begin
                    fails++; $display("[TB] FAIL rand%0d_write%0d got a=%0d d=%h be=%b want a=%0d d=%h be=%b", it, w, wrAddr[w], wrData[w], wrBe[w], w, expData[w], expBe[w]); end
            end
            tests++; if (word_count !== 16'(expCount) || checksum !== expSum || doneCount !== 1 || error !== 1'b0) begin
                fails++; $display("[TB] FAIL rand%0d_totals got wc=%0d sum=%h done=%0d err=%b want %0d/%h/1/0", it, word_count, checksum, doneCount, error, expCount, expSum); end
        end
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        int n;
        logic [31:0] saved [DEPTH];
        n = int'($urandom_range(9, 16));
        fill_random(n);
        build_model(n);
        clear_env();
        start_pulse();
        feed(n, n - 1, 0, 1'b0, to1);
        wait_end(to2);
        for (int w = 0; w < DEPTH; w++) saved[w] = mem[w];
        clear_env();
        start_pulse();
        feed(n, n - 1, 40, 1'b1, to1);
        wait_end(to2);
        tests++; if (to1 || to2) begin fails++; $display("[TB] FAIL b2b_timeout got %b%b want 00", to1, to2); end
        for (int w = 0; w < DEPTH; w++) begin
            tests++; if (mem[w] !== saved[w]) begin
                fails++; $display("[TB] FAIL b2b_mem%0d got %h want %h", w, mem[w], saved[w]); end
        end
        tests++; if (word_count !== 16'(expCount) || checksum !== expSum || doneCount !== 1 || wrAddr.size() !== expCount) begin
            fails++; $display("[TB] FAIL b2b_totals got wc=%0d sum=%h done=%0d n=%0d want %0d/%h/1/%0d", word_count, checksum, doneCount, wrAddr.size(), expCount, expSum, expCount); end
        tests++; if (readyDuringWrite !== 0) begin
            fails++; $display("[TB] FAIL b2b_ready_in_write got %0d want 0", readyDuringWrite); end
    endtask

    task automatic test_reset_mid_load();
        bit to1, to2;
        clear_env();
        fill_random(16);
        start_pulse();
        feed(6, -1, 0, 1'b0, to1);
        tests++; if (to1 || wrAddr.size() !== 1 || in_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL midload_pre got n=%0d rdy=%b to=%b want 1/1/0", wrAddr.size(), in_ready, to1); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error, mem_clken} !== 8'b0000_0001 ||
                     word_count !== '0 || checksum !== 32'h0) begin
            fails++; $display("[TB] FAIL midload_reset got ctl=%b wc=%0d sum=%h want 00000001/0/0",
                {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error, mem_clken}, word_count, checksum); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        tests++; if (wrAddr.size() !== 1) begin fails++; $display("[TB] FAIL midload_abort got n=%0d want 1", wrAddr.size()); end
        clear_env();
        build_model(4);
        start_pulse();
        feed(4, 3, 0, 1'b0, to1);
        wait_end(to2);
        tests++; if (to1 || to2 || wrAddr.size() !== 1 || wrAddr[0] !== 0 || wrData[0] !== expData[0] || doneCount !== 1) begin
            fails++; $display("[TB] FAIL midload_restart got n=%0d a=%0d d=%h done=%0d want 1/0/%h/1", wrAddr.size(), wrAddr[0], wrData[0], doneCount, expData[0]); end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired after %0d tests", tests);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_eight_bytes();
        test_partial_word();
        test_overflow();
        test_verify_corrupt();
        test_random_images();
        test_back_to_back();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
